// File: rtl/filt_decim_buf.sv
// Post-filter stage: blanks the stream while the filter settles after a mode
// change, decimates by a run-time factor and buffers kept samples in a show-ahead FIFO.
module filt_decim_buf #(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned SETTLE = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] din,
  input  logic [3:0]    decim,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE - 1);
  localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(DEPTH);

  typedef enum logic {S_SETTLE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [3:0]      phase_q, phase_d;
  logic [3:0]      n_q, n_d, n_eff;
  logic [1:0]      mode_d_q;
  logic            kept;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q;
  logic            push, pop, full;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    phase_d      = phase_q;
    n_d          = n_q;
    n_eff        = n_q;
    kept         = 1'b0;
    if (mode != mode_d_q) begin
      state_d      = S_SETTLE;
      settle_cnt_d = SETTLE_INIT;
      phase_d      = '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d = S_RUN;
            phase_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q - CW'(1);
          end
        end
        S_RUN: begin
          // N is latched only at the start of a period; mid-period decim edits wait.
          if (phase_q == '0) begin
            kept  = 1'b1;
            n_eff = (decim == '0) ? 4'd1 : decim;
            n_d   = n_eff;
          end
          phase_d = (({1'b0, phase_q} + 5'd1) >= {1'b0, n_eff}) ? '0 : phase_q + 4'd1;
        end
        default: state_d = S_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= SETTLE_INIT;
      phase_q      <= '0;
      n_q          <= 4'd1;
      mode_d_q     <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      phase_q      <= phase_d;
      n_q          <= n_d;
      mode_d_q     <= mode;
    end
  end

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) & dout_ready;
  assign push = kept & (~full | pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (kept & ~push)  overflow_q <= 1'b1;
      else if (clr_ovf)  overflow_q <= 1'b0;
    end
  end

  assign dout_valid = (count_q != '0);
  assign dout       = dout_valid ? mem_q[rd_q] : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule
